restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 164 ++++++++++++++++
 tb/tb_restoring_divider.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle restoring divider, one quotient bit per clock.
//
// Build option: DIVIDER_SIGNED_EN -- when defined, operands and results are two's
// complement (quotient truncates toward zero, remainder takes the dividend's sign).
// When undefined, everything is unsigned. Latency is identical in both builds.
//
// Ports:
//   clk          clock, rising-edge
//   rst          asynchronous reset, active low
//   start        request a division; sampled only while idle
//   dividend     numerator, captured when start is accepted
//   divisor      denominator, captured when start is accepted
//   quotient     registered result
//   remainder    registered result
//   done         one-cycle pulse: results valid
//   busy         high from acceptance of start until done
//   div_by_zero  divisor was zero; valid with the results
//
// Timing: done is seen N+1 edges after the accepting edge (N+2 edges counting that
// edge); a zero divisor skips the iterations and finishes one edge after acceptance.
module restoring_divider #(
   parameter int unsigned N = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         done,
   output logic         busy,
   output logic         div_by_zero
);

   localparam int unsigned CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LastIter = CW'(N - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic [N-1:0]   quo_q;   // dividend magnitude shifting out, quotient bits shifting in
   logic [N-1:0]   rem_q;   // partial remainder
   logic [N-1:0]   dsr_q;   // divisor magnitude
   logic           dbz_q;

   logic [N-1:0]   mag_a, mag_b;
   logic [N:0]     r_sh;
   logic [N+1:0]   diff;
   logic           fits;
   logic           unused_diff_msb;

`ifdef DIVIDER_SIGNED_EN
   logic sign_a, sign_b;
   logic neg_quo_q, neg_rem_q;

   assign sign_a = dividend[N-1];
   assign sign_b = divisor[N-1];
   // Negating MIN gives MIN, which read as unsigned is the correct magnitude 2^(N-1).
   assign mag_a  = sign_a ? -dividend : dividend;
   assign mag_b  = sign_b ? -divisor : divisor;
`else
   assign mag_a  = dividend;
   assign mag_b  = divisor;
`endif

   // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
   assign r_sh = {rem_q, quo_q[N-1]};
   assign diff = {1'b0, r_sh} - {2'b00, dsr_q};
   assign fits = ~diff[N+1];
   // A successful subtraction leaves a value below the divisor, so bit N is always 0.
   assign unused_diff_msb = diff[N];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (divisor == '0) ? StFix : StCalc;
            end
         end
         StCalc: begin
            if (cnt_q == LastIter) begin
               state_d = StFix;
            end
         end
         StFix:   state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dsr_q       <= '0;
         dbz_q       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  quo_q     <= mag_a;
                  rem_q     <= '0;
                  dsr_q     <= mag_b;
                  cnt_q     <= '0;
                  dbz_q     <= (divisor == '0);
`ifdef DIVIDER_SIGNED_EN
                  neg_quo_q <= sign_a ^ sign_b;
                  neg_rem_q <= sign_a;
`endif
               end
            end
            StCalc: begin
               cnt_q <= cnt_q + 1'b1;
               quo_q <= {quo_q[N-2:0], fits};
               rem_q <= fits ? diff[N-1:0] : r_sh[N-1:0];
            end
            StFix: begin
               div_by_zero <= dbz_q;
               if (dbz_q) begin
                  // quo_q still holds the untouched dividend magnitude.
                  quotient <= '1;
`ifdef DIVIDER_SIGNED_EN
                  remainder <= neg_rem_q ? -quo_q : quo_q;
`else
                  remainder <= quo_q;
`endif
               end else begin
`ifdef DIVIDER_SIGNED_EN
                  quotient  <= neg_quo_q ? -quo_q : quo_q;
                  remainder <= neg_rem_q ? -rem_q : rem_q;
`else
                  quotient  <= quo_q;
                  remainder <= rem_q;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign done = (state_q == StDone);
   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: scoreboard bench for restoring_divider (N = 64).
// Expected results are queued when an operation is started and compared whenever
// done pulses. Follows the DUT build: define DIVIDER_SIGNED_EN for both to test signed.
module tb_restoring_divider;

   localparam int unsigned N = 64;
   localparam int LatNorm = N + 2;
   localparam int LatDbz  = 2;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dbz;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] dividend, divisor;
   logic [N-1:0] quotient, remainder;
   logic         done, busy, div_by_zero;

   exp_t sb_q[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   int   done_cnt = 0;

   restoring_divider #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .quotient   (quotient),
      .remainder  (remainder),
      .done       (done),
      .busy       (busy),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      logic [N-1:0] min_v;
      min_v = '0;
      min_v[N-1] = 1'b1;
      e.dbz = 1'b0;
      if (b == '0) begin
         e.q   = '1;
         e.r   = a;
         e.dbz = 1'b1;
`ifdef DIVIDER_SIGNED_EN
      end else if (a == min_v && b == '1) begin
         e.q = min_v;
         e.r = '0;
      end else begin
         e.q = $signed(a) / $signed(b);
         e.r = $signed(a) % $signed(b);
`else
      end else begin
         e.q = a / b;
         e.r = a % b;
`endif
      end
      return e;
   endfunction

   // Scoreboard side: compare on every done pulse.
   always @(negedge clk) begin
      if (rst === 1'b1 && done === 1'b1) begin
         exp_t e;
         done_cnt++;
         if (sb_q.size() == 0) begin
            check_eq("unexpected_done", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check_eq("quotient", quotient, e.q);
            check_eq("remainder", remainder, e.r);
            check_eq("div_by_zero", div_by_zero, e.dbz);
         end
      end
   end

   // Start one op from idle (called #1 after an edge) and check its timing.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int exp_lat);
      int cyc;
      int busy_cyc;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      sb_q.push_back(model(a, b));
      @(posedge clk); #1;
      start    = 1'b0;
      cyc      = 1;
      busy_cyc = busy ? 1 : 0;
      while (!done && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (busy) busy_cyc++;
      end
      check_eq("latency", cyc, exp_lat);
      check_eq("busy_cycles", busy_cyc, exp_lat);
      @(posedge clk); #1;
      check_eq("done_one_cycle", done, 0);
      check_eq("busy_back_idle", busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      int dcnt;
      logic [N-1:0] min_v;
      logic [N-1:0] ra, rb;
      rst      = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #3;
      check_eq("rst_quotient", quotient, 0);
      check_eq("rst_remainder", remainder, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_dbz", div_by_zero, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      run_op(100, 7, LatNorm);
      run_op(64'h1234, 0, LatDbz);
      run_op(5, 10, LatNorm);
      run_op('1, 1, LatNorm);
      run_op('1, '1, LatNorm);
      run_op(1, 3, LatNorm);
      run_op(0, 9, LatNorm);
      for (int i = 0; i < 6; i++) begin
         ra = {$urandom, $urandom};
         rb = (i % 2 == 0) ? N'($urandom_range(1, 1000)) : {$urandom, $urandom | 32'h1};
         run_op(ra, rb, LatNorm);
      end

`ifdef DIVIDER_SIGNED_EN
      min_v = '0;
      min_v[N-1] = 1'b1;
      run_op(-64'sd100, 7, LatNorm);
      run_op(100, -64'sd7, LatNorm);
      run_op(min_v, '1, LatNorm);
      run_op(-64'sd9, -64'sd4, LatNorm);
      run_op(-64'sd5, 0, LatDbz);
`endif

      // start held high through a run, operands scrambled while busy.
      dividend = 50;
      divisor  = 5;
      start    = 1'b1;
      sb_q.push_back(model(50, 5));
      @(posedge clk); #1;
      cyc = 1;
      while (!done && cyc < 200) begin
         dividend = {$urandom, $urandom};
         divisor  = N'($urandom_range(0, 3));
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("held_latency", cyc, LatNorm);
      dividend = 21;
      divisor  = 4;
      sb_q.push_back(model(21, 4));
      @(posedge clk); #1;
      check_eq("held_idle_gap_busy", busy, 0);
      @(posedge clk); #1;
      check_eq("held_reaccept_busy", busy, 1);
      start = 1'b0;
      check_eq("held_result_kept", quotient, 10);
      cyc = 1;
      while (!done && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("second_latency", cyc, LatNorm);
      @(posedge clk); #1;

      // Reset in the middle of iterating: everything clears, no completion.
      dividend = 1000;
      divisor  = 3;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #2;
      dcnt = done_cnt;
      rst  = 1'b0;
      #1;
      check_eq("abort_quotient", quotient, 0);
      check_eq("abort_remainder", remainder, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_dbz", div_by_zero, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (80) @(posedge clk);
      #1;
      check_eq("abort_no_done", done_cnt, dcnt);
      check_eq("abort_idle", busy, 0);
      run_op(9, 4, LatNorm);

      check_eq("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
